// File: rtl/store_narrow.sv
// rtl/store_narrow.sv - store-side narrowing: fit check plus little-endian byte streaming
module store_narrow #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              fit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [63:0]       data_q;
  logic [1:0]        size_q;
  logic [2:0]        cnt_q;
  logic              req_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              done_q;
  logic              fit_q;

  logic              fit_d;
  logic [2:0]        cnt_d;
  logic [3:0]        nbytes;
  logic              last_beat;
  logic [5:0]        bit_sel_d;
  logic [7:0]        wdata_d;
  logic [ADDR_W-1:0] addr_d;

  // The value fits when extending its low w bits (signed or unsigned) rebuilds it exactly.
  function automatic logic fit_check(input logic [63:0] d, input logic [1:0] s, input logic sg);
    logic [63:0] ext;
    case (s)
      2'b00:   ext = sg ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      2'b01:   ext = sg ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      2'b10:   ext = sg ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      default: ext = d;
    endcase
    return ext == d;
  endfunction

  // Next-beat address/data and end-of-transfer detection from captured state.
  always_comb begin
    fit_d     = fit_check(req_data, req_size, req_signed);
    cnt_d     = cnt_q + 3'd1;
    nbytes    = 4'd1 << size_q;
    last_beat = ({1'b0, cnt_q} == (nbytes - 4'd1));
    bit_sel_d = {cnt_d, 3'b000};
    wdata_d   = data_q[bit_sel_d +: 8];
    addr_d    = base_q + ADDR_W'(cnt_d);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      data_q      <= '0;
      size_q      <= 2'd0;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      done_q      <= 1'b0;
      fit_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= SEND;
            base_q      <= req_addr;
            data_q      <= req_data;
            size_q      <= req_size;
            cnt_q       <= 3'd0;
            fit_q       <= fit_d;
            req_ready_q <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_data[7:0];
          end
        end
        SEND: begin
          // Without an ack every output simply holds its value.
          if (mem_ack) begin
            if (last_beat) begin
              state_q  <= DONE;
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q       <= cnt_d;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          mem_we_q    <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign fit       = fit_q;

endmodule

// File: tb/tb_store_narrow.sv
// tb/tb_store_narrow.sv - randomized self-checking bench for store_narrow
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        fit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_narrow #(.ADDR_W(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .req_signed (req_signed),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .done       (done),
    .fit        (fit)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Range-based fit: does the value lie in the representable range of a w-bit integer?
  function automatic logic model_fit(input logic [63:0] d, input logic [1:0] s, input logic sg);
    int     w;
    longint sd;
    longint lim;
    w = 8 << s;
    if (s == 2'd3) return 1'b1;
    sd  = longint'(d);
    lim = longint'(1) << (w - 1);
    if (sg) return (sd >= -lim) && (sd < lim);
    return d < (64'd1 << w);
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge where req_ready is back to 1.
  task automatic do_store(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size,
                          input logic sgn, input int mode, input logic busy,
                          input logic [63:0] b_addr, input logic [63:0] b_data,
                          input logic [1:0] b_size, input logic b_sgn);
    int   nb;
    int   k;
    int   cyc;
    logic a;
    logic exp_fit;
    nb      = 1 << size;
    k       = 0;
    cyc     = 0;
    exp_fit = model_fit(data, size, sgn);
    check_eq("idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_data   = data;
    req_size   = size;
    req_signed = sgn;
    mem_ack    = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (busy) begin
      req_valid  = 1'b1;
      req_addr   = b_addr;
      req_data   = b_data;
      req_size   = b_size;
      req_signed = b_sgn;
    end else begin
      req_valid  = 1'b0;
      req_addr   = {$urandom, $urandom};
      req_data   = {$urandom, $urandom};
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
    end
    while (k < nb && cyc < 100) begin
      check_eq("send_we", {63'd0, mem_we}, 64'd1);
      check_eq("send_ready", {63'd0, req_ready}, 64'd0);
      check_eq("send_done", {63'd0, done}, 64'd0);
      check_eq("send_addr", mem_addr, addr + 64'(k));
      check_eq("send_wdata", {56'd0, mem_wdata}, (data >> (8 * k)) & 64'hFF);
      case (mode)
        0:       a = 1'b1;
        1:       a = (cyc % 2) == 1;
        default: a = ($urandom_range(0, 3) != 0);
      endcase
      mem_ack = a;
      if (a) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < nb) begin
      check_eq("ack_timeout", 64'(k), 64'(nb));
      return;
    end
    mem_ack = 1'($urandom_range(0, 1));
    check_eq("done_pulse", {63'd0, done}, 64'd1);
    check_eq("done_fit", {63'd0, fit}, {63'd0, exp_fit});
    check_eq("done_we", {63'd0, mem_we}, 64'd0);
    check_eq("done_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check_eq("post_done", {63'd0, done}, 64'd0);
    check_eq("post_fit", {63'd0, fit}, {63'd0, exp_fit});
    check_eq("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size,
                       input logic sgn, input int mode);
    do_store(addr, data, size, sgn, mode, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] d;
    int          sh;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 64'd0;
    req_data   = 64'd0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    mem_ack    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_we", {63'd0, mem_we}, 64'd0);
    check_eq("rst_addr", mem_addr, 64'd0);
    check_eq("rst_wdata", {56'd0, mem_wdata}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_fit", {63'd0, fit}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    store(64'h100, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b1, 0);
    store(64'h100, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b0, 0);
    store(64'h200, 64'h0000_0001_1234_5678, 2'd2, 1'b1, 1);
    store(64'h300, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 0);
    store(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_7F01, 2'd1, 1'b1, 2);

    // Second request held during SEND must not be captured and is taken only after done.
    do_store(64'h400, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0, 2, 1'b1,
             64'h500, 64'hFFFF_FFFF_8000_0000, 2'd2, 1'b1);
    store(64'h500, 64'hFFFF_FFFF_8000_0000, 2'd2, 1'b1, 0);

    // Reset while the third byte of a dword store is on the bus.
    req_valid  = 1'b1;
    req_addr   = 64'h2000;
    req_data   = 64'h1122_3344_5566_7788;
    req_size   = 2'd3;
    req_signed = 1'b0;
    mem_ack    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_addr", mem_addr, 64'h2002);
    check_eq("pre_rst_wdata", {56'd0, mem_wdata}, 64'h66);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_we", {63'd0, mem_we}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("mid_rst_done", {63'd0, done}, 64'd0);
    check_eq("mid_rst_addr", mem_addr, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("after_rst_done", {63'd0, done}, 64'd0);
      check_eq("after_rst_we", {63'd0, mem_we}, 64'd0);
    end
    mem_ack = 1'b0;
    store(64'h3000, 64'h0000_0000_0000_00FF, 2'd0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      d  = {$urandom, $urandom};
      sh = $urandom_range(0, 63);
      d  = $urandom_range(0, 1) ? (d >> sh) : ~(d >> sh);
      store({$urandom, $urandom}, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
